mem_arbiter: RTL and testbench

Two-master, one-slave memory arbiter sitting directly downstream of the instruction-side and data-side cache management units, merging their miss/write-back traffic onto a single unified memory with variable-latency ack handshake. Lets both CMUs share one `data_ram`-style array (CLK_DELAY-cycle ack) so instruction and data live in one address space. Grants one request at a time, returns read data and a one-cycle ack to the owner, and flags memories that never answer.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states and grant owners.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Merges instruction-side and data-side CMU traffic onto one ack-handshake memory,
// one transaction at a time, with a watchdog that flags a memory that never answers.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_cs_i,
  input  logic        inst_we_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_data_i,
  output logic [31:0] inst_data_o,
  output logic        inst_ack_o,
  input  logic        data_cs_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_data_i,
  output logic [31:0] data_data_o,
  output logic        data_ack_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] ret_word;
  logic        timeout_hit;

  // Fires on the last permitted BUSY cycle; the counter reads 0 in the first one.
  assign timeout_hit = (TIMEOUT != 16'd0) && (wd_cnt_q == (TIMEOUT - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= GNT_INST;
      last_grant_q <= GNT_INST;
      wd_cnt_q     <= '0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    ret_word     = mem_ack_i ? mem_data_i : 32'h0;

    case (state_q)
      ARB_IDLE: begin
        if (inst_cs_i || data_cs_i) begin
          if (inst_cs_i && data_cs_i)
            grant_d = DATA_FIRST ? GNT_DATA : ~last_grant_q;
          else
            grant_d = data_cs_i ? GNT_DATA : GNT_INST;
          wd_cnt_d = '0;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ack_i || timeout_hit) begin
          if (grant_q == GNT_DATA)
            data_rdata_d = ret_word;
          else
            inst_rdata_d = ret_word;
          if (!mem_ack_i)
            err_d = 1'b1;
          state_d = ARB_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      ARB_DONE: begin
        last_grant_d = grant_q;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory-side strobes decode from registered state only; address and data
  // follow the owner's live inputs, which it holds until its ack.
  assign mem_cs_o   = (state_q == ARB_BUSY);
  assign mem_we_o   = mem_cs_o && ((grant_q == GNT_DATA) ? data_we_i : inst_we_i);
  assign mem_addr_o = !mem_cs_o ? 32'h0 : ((grant_q == GNT_DATA) ? data_addr_i : inst_addr_i);
  assign mem_data_o = !mem_cs_o ? 32'h0 : ((grant_q == GNT_DATA) ? data_data_i : inst_data_i);

  assign inst_ack_o  = (state_q == ARB_DONE) && (grant_q == GNT_INST);
  assign data_ack_o  = (state_q == ARB_DONE) && (grant_q == GNT_DATA);
  assign inst_data_o = inst_rdata_q;
  assign data_data_o = data_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: lane 0 is data-first, lane 1 round-robin; both share master
// stimulus, each has its own delayed-ack memory and a transaction-level reference model.
module tb_mem_arbiter;

  localparam int          LANES    = 2;
  localparam logic [15:0] WD_LIMIT = 16'd20;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_cs, inst_we, data_cs, data_we;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;

  logic [31:0] inst_rdata [LANES];
  logic [31:0] data_rdata [LANES];
  logic        inst_ack   [LANES];
  logic        data_ack   [LANES];
  logic        mem_cs     [LANES];
  logic        mem_we     [LANES];
  logic [31:0] mem_addr   [LANES];
  logic [31:0] mem_wdata  [LANES];
  logic [31:0] mem_rdata  [LANES] = '{32'h0, 32'h0};
  logic        mem_ack    [LANES] = '{1'b0, 1'b0};
  logic        err        [LANES];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_arbiter #(.DATA_FIRST(g == 0), .TIMEOUT(WD_LIMIT)) u_dut (
      .clk(clk), .rst(rst),
      .inst_cs_i(inst_cs), .inst_we_i(inst_we), .inst_addr_i(inst_addr),
      .inst_data_i(inst_wdata), .inst_data_o(inst_rdata[g]), .inst_ack_o(inst_ack[g]),
      .data_cs_i(data_cs), .data_we_i(data_we), .data_addr_i(data_addr),
      .data_data_i(data_wdata), .data_data_o(data_rdata[g]), .data_ack_o(data_ack[g]),
      .mem_cs_o(mem_cs[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_data_o(mem_wdata[g]), .mem_data_i(mem_rdata[g]), .mem_ack_i(mem_ack[g]),
      .err_o(err[g])
    );
  end

  // Memory: acks once cs has been held for mem_delay full cycles; any cs-low cycle restarts it.
  int unsigned mem_delay = 8;
  bit          mem_mute  = 1'b0;
  logic [31:0] rd_word   = 32'h0;
  int          mem_cnt [LANES] = '{0, 0};

  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      int nxt;
      nxt = (mem_cs[l] === 1'b1) ? mem_cnt[l] + 1 : 0;
      mem_cnt[l]   <= nxt;
      mem_ack[l]   <= !mem_mute && (nxt == int'(mem_delay) + 1);
      mem_rdata[l] <= (nxt == int'(mem_delay) + 1) ? rd_word : 32'hDEADBEEF;
    end
  end

  // Reference model: one open transaction per lane, owner chosen by the priority rule.
  bit        m_open  [LANES];
  bit        m_done  [LANES];
  bit        m_owner [LANES];
  bit        m_last  [LANES];
  bit        m_err   [LANES];
  int        m_busy  [LANES];
  bit [31:0] m_rd    [LANES][2];

  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (rst) begin
        m_open[l] <= 1'b0; m_done[l] <= 1'b0; m_last[l] <= 1'b0; m_err[l] <= 1'b0;
        m_busy[l] <= 0;    m_rd[l][0] <= '0;  m_rd[l][1] <= '0;
      end else if (m_done[l]) begin
        m_done[l] <= 1'b0;
        m_last[l] <= m_owner[l];
      end else if (m_open[l]) begin
        m_busy[l] <= m_busy[l] + 1;
        if (mem_ack[l]) begin
          m_rd[l][m_owner[l]] <= mem_rdata[l];
          m_open[l] <= 1'b0;
          m_done[l] <= 1'b1;
        end else if (m_busy[l] + 1 == int'(WD_LIMIT)) begin
          m_rd[l][m_owner[l]] <= '0;
          m_err[l]  <= 1'b1;
          m_open[l] <= 1'b0;
          m_done[l] <= 1'b1;
        end
      end else if (inst_cs || data_cs) begin
        if (inst_cs && data_cs)
          m_owner[l] <= (l == 0) ? 1'b1 : !m_last[l];
        else
          m_owner[l] <= data_cs;
        m_open[l] <= 1'b1;
        m_busy[l] <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    logic        e_we;
    logic [31:0] e_addr, e_data;
    for (int l = 0; l < LANES; l++) begin
      e_we   = m_open[l] && (m_owner[l] ? data_we : inst_we);
      e_addr = !m_open[l] ? 32'h0 : (m_owner[l] ? data_addr : inst_addr);
      e_data = !m_open[l] ? 32'h0 : (m_owner[l] ? data_wdata : inst_wdata);
      checkOutput($sformatf("L%0d mem_cs", l), 32'(mem_cs[l]), 32'(m_open[l]));
      checkOutput($sformatf("L%0d mem_we", l), 32'(mem_we[l]), 32'(e_we));
      checkOutput($sformatf("L%0d mem_addr", l), mem_addr[l], e_addr);
      checkOutput($sformatf("L%0d mem_data", l), mem_wdata[l], e_data);
      checkOutput($sformatf("L%0d inst_ack", l), 32'(inst_ack[l]), 32'(m_done[l] && !m_owner[l]));
      checkOutput($sformatf("L%0d data_ack", l), 32'(data_ack[l]), 32'(m_done[l] && m_owner[l]));
      checkOutput($sformatf("L%0d inst_data", l), inst_rdata[l], m_rd[l][0]);
      checkOutput($sformatf("L%0d data_data", l), data_rdata[l], m_rd[l][1]);
      checkOutput($sformatf("L%0d err", l), 32'(err[l]), 32'(m_err[l]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ics, input logic iwe, input logic [31:0] iad,
                               input logic [31:0] idt, input logic dcs, input logic dwe,
                               input logic [31:0] dad, input logic [31:0] ddt);
    inst_cs = ics; inst_we = iwe; inst_addr = iad; inst_wdata = idt;
    data_cs = dcs; data_we = dwe; data_addr = dad; data_wdata = ddt;
  endtask

  task automatic idleMasters();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleMasters();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until the wanted ack is seen on a lane; lat counts cycles from the call.
  task automatic waitAck(input int lane, input bit want_data, output int lat,
                         output int stray, output logic cs_at_ack);
    bit seen;
    seen = 1'b0; lat = -1; stray = 0; cs_at_ack = 1'bx;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      compareAll();
      if ((want_data ? inst_ack[lane] : data_ack[lane]) === 1'b1) stray++;
      if ((want_data ? data_ack[lane] : inst_ack[lane]) === 1'b1) begin
        seen = 1'b1; lat = k; cs_at_ack = mem_cs[lane];
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int       lat, stray, acks0, acks1, hits;
    logic     cs_ack;
    bit [3:0] seq0, seq1;

    rst = 1'b1;
    idleMasters();
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    checkOutput("reset mem_cs", 32'(mem_cs[0]), 32'h0);
    checkOutput("reset err", 32'(err[0]), 32'h0);
    checkOutput("reset inst_data", inst_rdata[0], 32'h0);

    $display("[TB] lone instruction read");
    rd_word = 32'h8C010004;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitAck(0, 1'b0, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t1 inst latency", lat, 32'd10);
    checkOutput("t1 data_ack pulses", stray, 32'd0);
    checkOutput("t1 inst_data", inst_rdata[0], 32'h8C010004);

    $display("[TB] simultaneous data write and instruction read");
    rd_word = 32'h12345678;
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    tick();
    checkOutput("t2 mem_we", 32'(mem_we[0]), 32'h1);
    checkOutput("t2 mem_addr", mem_addr[0], 32'h40);
    checkOutput("t2 mem_data", mem_wdata[0], 32'hCAFEF00D);
    waitAck(0, 1'b1, lat, stray, cs_ack);
    checkOutput("t2 data latency", lat, 32'd9);
    checkOutput("t2 early inst_ack", stray, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitAck(0, 1'b0, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t2 inst latency after data ack", lat, 32'd10);
    checkOutput("t2 inst_data", inst_rdata[0], 32'h12345678);

    $display("[TB] continuous requests from both masters");
    doReset();
    rd_word = 32'h00C0FFEE;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    seq0 = '0; seq1 = '0; acks0 = 0; acks1 = 0;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      compareAll();
      if (inst_ack[0] === 1'b1 || data_ack[0] === 1'b1) begin
        seq0 = {seq0[2:0], data_ack[0] === 1'b1}; acks0++;
      end
      if (inst_ack[1] === 1'b1 || data_ack[1] === 1'b1) begin
        seq1 = {seq1[2:0], data_ack[1] === 1'b1}; acks1++;
      end
      @(posedge clk);
      #1;
    end
    idleMasters();
    checkOutput("t3 data-first ack count", acks0, 32'd4);
    checkOutput("t3 data-first order", 32'(seq0), 32'h0000000F);
    checkOutput("t3 round-robin ack count", acks1, 32'd4);
    checkOutput("t3 round-robin order", 32'(seq1), 32'h0000000A);
    for (int k = 0; k < 14; k++) tick();

    $display("[TB] watchdog on a silent memory");
    doReset();
    rd_word = 32'hA5A50F0F;
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitAck(0, 1'b0, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t4 primed inst_data", inst_rdata[0], 32'hA5A50F0F);
    mem_mute = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitAck(0, 1'b0, lat, stray, cs_ack);
    idleMasters();
    mem_mute = 1'b0;
    checkOutput("t4 timeout latency", lat, 32'd21);
    checkOutput("t4 timeout inst_data", inst_rdata[0], 32'h0);
    checkOutput("t4 err set", 32'(err[0]), 32'h1);
    checkOutput("t4 err set lane1", 32'(err[1]), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0);
    waitAck(0, 1'b1, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t4 normal latency after timeout", lat, 32'd10);
    checkOutput("t4 err sticky", 32'(err[0]), 32'h1);

    $display("[TB] reset during an access");
    rd_word = 32'h0BADF00D;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("t5 busy before reset", 32'(mem_cs[0]), 32'h1);
    rst = 1'b1;
    idleMasters();
    tick();
    rst = 1'b0;
    checkOutput("t5 mem_cs after reset", 32'(mem_cs[0]), 32'h0);
    checkOutput("t5 err after reset", 32'(err[0]), 32'h0);
    checkOutput("t5 data_data after reset", data_rdata[0], 32'h0);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      compareAll();
      if (inst_ack[0] === 1'b1 || data_ack[0] === 1'b1) hits++;
      @(posedge clk);
      #1;
    end
    checkOutput("t5 acks after dropped access", hits, 32'd0);
    rd_word = 32'h600DF00D;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
    waitAck(0, 1'b1, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t5 latency after reset", lat, 32'd10);
    checkOutput("t5 data_data", data_rdata[0], 32'h600DF00D);

    $display("[TB] back-to-back data requests");
    rd_word = 32'h11112222;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    waitAck(0, 1'b1, lat, stray, cs_ack);
    checkOutput("t6 first latency", lat, 32'd10);
    checkOutput("t6 mem_cs in ack cycle", 32'(cs_ack), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0);
    checkOutput("t6 mem_cs in idle cycle", 32'(mem_cs[0]), 32'h0);
    rd_word = 32'h33334444;
    waitAck(0, 1'b1, lat, stray, cs_ack);
    idleMasters();
    checkOutput("t6 second latency (11-cycle interval)", lat, 32'd10);
    checkOutput("t6 data_data", data_rdata[0], 32'h33334444);
    for (int k = 0; k < 3; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
